// File: rtl/misr_sig_unload.sv
// Gates the upstream MISR for a programmed window, captures and checks the signature, then
// unloads it LSB-first over valid/ready. Define MISR_SIG_PARITY_EN to append an even-parity bit.
module misr_sig_unload #(
  parameter int unsigned SIG_W = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             start,
  input  logic [CNT_W-1:0] win_len,
  input  logic [SIG_W-1:0] golden,
  input  logic [SIG_W-1:0] sig_in,
  output logic             misr_clr,
  output logic             misr_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             ser_out,
  output logic             ser_valid,
  input  logic             ser_ready
);

`ifdef MISR_SIG_PARITY_EN
  localparam int unsigned UnloadLen = SIG_W + 1;
`else
  localparam int unsigned UnloadLen = SIG_W;
`endif
  localparam int unsigned BitW = $clog2(UnloadLen + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(UnloadLen - 1);

  typedef enum logic [2:0] {
    StIdle, StClear, StRun, StCapture, StCompare, StUnload
  } state_e;

  state_e                 state_q;
  logic [CNT_W-1:0]       win_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [SIG_W-1:0]       gold_q;
  logic [UnloadLen-1:0]   shift_q;
  logic [BitW-1:0]        bit_q;

  always_ff @(posedge CK) begin
    if (RESET) begin
      state_q   <= StIdle;
      win_q     <= '0;
      cnt_q     <= '0;
      gold_q    <= '0;
      shift_q   <= '0;
      bit_q     <= '0;
      misr_clr  <= 1'b0;
      misr_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            win_q    <= win_len;
            gold_q   <= golden;
            pass     <= 1'b0;
            misr_clr <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StClear;
          end
        end
        StClear: begin
          misr_clr <= 1'b0;
          if (win_q != '0) begin
            cnt_q   <= win_q;
            misr_en <= 1'b1;
            state_q <= StRun;
          end else begin
            // Zero-length window captures the freshly cleared MISR.
            state_q <= StCapture;
          end
        end
        StRun: begin
          if (cnt_q == CNT_W'(1)) begin
            misr_en <= 1'b0;
            state_q <= StCapture;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StCapture: begin
`ifdef MISR_SIG_PARITY_EN
          shift_q <= {^sig_in, sig_in};
`else
          shift_q <= sig_in;
`endif
          state_q <= StCompare;
        end
        StCompare: begin
          pass      <= (shift_q[SIG_W-1:0] == gold_q);
          bit_q     <= '0;
          ser_out   <= shift_q[0];
          ser_valid <= 1'b1;
          state_q   <= StUnload;
        end
        StUnload: begin
          if (ser_ready) begin
            if (bit_q == LastBit) begin
              ser_valid <= 1'b0;
              ser_out   <= 1'b0;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_q   <= StIdle;
            end else begin
              shift_q <= shift_q >> 1;
              ser_out <= shift_q[1];
              bit_q   <= bit_q + 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_misr_sig_unload.sv
// Randomized self-checking bench for misr_sig_unload; honours MISR_SIG_PARITY_EN like the design.
module tb_misr_sig_unload;

`ifdef MISR_SIG_PARITY_EN
  localparam int unsigned Len = 33;
`else
  localparam int unsigned Len = 32;
`endif

  logic        CK = 1'b0;
  logic        RESET;
  logic        start;
  logic [15:0] win_len;
  logic [31:0] golden;
  logic [31:0] sig_in;
  logic        misr_clr, misr_en, busy, done, pass, ser_out, ser_valid;
  logic        ser_ready;

  int n_checks = 0;
  int n_fail   = 0;

  // Upstream MISR stand-in: clears to 0, advances by inc per enabled cycle.
  logic [31:0] up_q = 32'h1234_5678;
  logic [31:0] base = 32'h0;
  logic [31:0] inc  = 32'h0;
  assign sig_in = up_q ^ base;

  always #5 CK = ~CK;

  always @(posedge CK) begin
    if (misr_clr) up_q <= 32'h0;
    else if (misr_en) up_q <= up_q + inc;
  end

  misr_sig_unload #(
    .SIG_W(32),
    .CNT_W(16)
  ) dut (
    .CK       (CK),
    .RESET    (RESET),
    .start    (start),
    .win_len  (win_len),
    .golden   (golden),
    .sig_in   (sig_in),
    .misr_clr (misr_clr),
    .misr_en  (misr_en),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {misr_clr, misr_en, busy, done, pass, ser_out, ser_valid};
  endfunction

  // One full transaction; called and returns at a falling edge with the DUT idle.
  task automatic run_txn(input logic [15:0] win, input logic [31:0] gold, input logic [31:0] b,
                         input logic [31:0] i_inc, input bit rnd_ready, input bit stall7,
                         input bit poke);
    logic [31:0] exp_sig;
    logic [32:0] rx;
    int          rx_n, en_n, clr_n, stall_n, budget;
    bit          got_done, prev_wait, hs;
    logic        prev_out;
    exp_sig   = b ^ (32'(win) * i_inc);
    rx        = '0;
    rx_n      = 0;
    en_n      = 0;
    clr_n     = 0;
    stall_n   = 0;
    got_done  = 0;
    prev_wait = 0;
    prev_out  = 0;
    budget    = int'(win) + 1000;
    base      = b;
    inc       = i_inc;
    win_len   = win;
    golden    = gold;
    start     = 1'b1;
    @(negedge CK);
    start   = 1'b0;
    win_len = 16'($urandom);
    golden  = $urandom;
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (done) begin
        got_done = 1;
        break;
      end
      if (misr_clr) clr_n++;
      if (misr_en) en_n++;
      if (prev_wait) begin
        check("stall_valid", 64'(ser_valid), 64'(1));
        check("stall_data", 64'(ser_out), 64'(prev_out));
      end
      if (stall7 && ser_valid && rx_n == 7 && stall_n < 10) begin
        ser_ready = 1'b0;
        stall_n++;
      end else begin
        ser_ready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      end
      hs = ser_valid && ser_ready;
      if (hs && rx_n < 33) begin
        rx[rx_n] = ser_out;
        rx_n++;
      end
      prev_wait = ser_valid && !ser_ready;
      prev_out  = ser_out;
      start = (poke && ser_valid && $urandom_range(3, 0) == 0);
      @(negedge CK);
    end
    start = 1'b0;
    check("done_seen", 64'(got_done), 64'(1));
    check("bit_count", 64'(rx_n), 64'(Len));
    check("sig_bits", 64'(rx[31:0]), 64'(exp_sig));
`ifdef MISR_SIG_PARITY_EN
    check("parity_bit", 64'(rx[32]), 64'(^exp_sig));
`endif
    check("pass", 64'(pass), 64'(exp_sig == gold));
    check("en_cycles", 64'(en_n), 64'(win));
    check("clr_cycles", 64'(clr_n), 64'(1));
    check("end_valid_busy", 64'({ser_valid, busy}), 64'(0));
    @(negedge CK);
    check("done_pulse", 64'(done), 64'(0));
    check("pass_hold", 64'(pass), 64'(exp_sig == gold));
  endtask

  initial begin
    logic [31:0] r_inc, r_base, r_sig;
    logic [15:0] r_win;
    RESET     = 1'b1;
    start     = 1'b0;
    win_len   = 16'h0;
    golden    = 32'h0;
    ser_ready = 1'b0;
    repeat (3) @(negedge CK);
    check("reset_outs", 64'(outs()), 64'(0));
    RESET = 1'b0;
    @(negedge CK);

    // Reset in the middle of a long window.
    win_len = 16'd100;
    golden  = 32'h0;
    start   = 1'b1;
    @(negedge CK);
    start = 1'b0;
    repeat (41) @(negedge CK);
    check("mid_run_en", 64'(misr_en), 64'(1));
    RESET = 1'b1;
    @(negedge CK);
    RESET = 1'b0;
    check("mid_run_reset", 64'(outs()), 64'(0));
    @(negedge CK);
    r_inc = $urandom;
    run_txn(16'd5, 32'h0, $urandom, r_inc, 1'b0, 1'b0, 1'b0);

    // Directed signatures.
    r_inc = $urandom;
    run_txn(16'd3, 32'hDEADBEEF, 32'hDEADBEEF ^ (32'd3 * r_inc), r_inc, 1'b0, 1'b0, 1'b0);
    run_txn(16'd3, 32'hDEADBEEE, 32'hDEADBEEF ^ (32'd3 * r_inc), r_inc, 1'b0, 1'b0, 1'b0);
    run_txn(16'd0, 32'h0, 32'h0, $urandom, 1'b0, 1'b0, 1'b0);
    run_txn(16'd1, 32'h7, 32'h7 ^ r_inc, r_inc, 1'b1, 1'b0, 1'b0);

    // Stall on bit 7 with random ready and ignored start pulses.
    r_inc = $urandom;
    run_txn(16'd9, 32'h0, $urandom, r_inc, 1'b1, 1'b1, 1'b1);

    // Random windows; golden matches half the time.
    for (int t = 0; t < 6; t++) begin
      r_win  = 16'($urandom_range(20, 0));
      r_inc  = $urandom;
      r_base = $urandom;
      r_sig  = r_base ^ (32'(r_win) * r_inc);
      run_txn(r_win, (t % 2 == 0) ? r_sig : $urandom, r_base, r_inc, 1'b1, t == 3, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/misr_sig_unload.md
Name: misr_sig_unload

Overview:
- Downstream consumer of the 32-bit CRC/MISR signature register in the s35932 test-compaction path.
- Gates the upstream MISR for a programmed number of compaction cycles, then captures the final signature.
- Compares the captured signature with a golden value and unloads it serially over a valid/ready handshake to the tester interface.

Parameters:
SIG_W, 32, signature width (matches CRC_OUT_8_0..31)
CNT_W, 16, width of compaction-window counter

Ports:
CK  input  1  clock; all state updates on rising edge
RESET  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a compaction window (ignored unless IDLE)
win_len  input  CNT_W  number of compaction cycles; sampled on accepted start
golden  input  SIG_W  expected signature; sampled on accepted start
sig_in  input  SIG_W  current upstream MISR contents (CRC_OUT_8_[31:0])
misr_clr  output  1  drives upstream MISR clear (its RESET-low path)
misr_en  output  1  upstream MISR compaction enable
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when unload completes
pass  output  1  registered compare result; valid from COMPARE until next accepted start
ser_out  output  1  serial signature bit, LSB first
ser_valid  output  1  ser_out valid
ser_ready  input  1  tester accepts ser_out when ser_valid && ser_ready

Behaviour:
- Reset (RESET=1 at edge): state=IDLE; misr_clr=0, misr_en=0, busy=0, done=0, pass=0, ser_out=0, ser_valid=0; counters, shift register and latched golden/win_len cleared. Reset dominates all other inputs and aborts any operation in progress the same cycle.
- States: IDLE, CLEAR, RUN, CAPTURE, COMPARE, UNLOAD.
- IDLE: on start=1, latch win_len and golden, clear pass, go to CLEAR. start in any other state is ignored.
- CLEAR: one cycle; misr_clr=1. Next: RUN if latched win_len!=0, else CAPTURE (zero-length window captures the cleared value).
- RUN: misr_en=1; counter starts at win_len and decrements each cycle; in the cycle the counter reaches 1, go to CAPTURE. Exactly win_len cycles have misr_en=1.
- CAPTURE: misr_en=0; load sig_in into shift register. The one-cycle gap after the last enable lets the MISR settle.
- COMPARE: pass <= (shift register == latched golden); go to UNLOAD.
- UNLOAD: ser_valid=1, ser_out=shift[0]. On each handshake, shift right and increment the bit counter. ser_out/ser_valid hold stable while ser_ready=0. After the handshake of the final bit: ser_valid=0, done=1 for one cycle, return to IDLE.
- Unload length: SIG_W bits.
- Max win_len = 2^CNT_W-1; the counter never wraps. pass is not affected by ser_ready stalls.
- All outputs registered; no combinational input-to-output paths.

Optional Feature:
MISR_SIG_PARITY_EN
- Defined: after the SIG_W signature bits, one extra even-parity bit (XOR of the captured signature) is unloaded with the same handshake; unload length is SIG_W+1 and done follows the parity-bit handshake.
- Undefined: no parity bit; unload length is SIG_W.

Test Plan:
- Reset mid-RUN (win_len=100, RESET asserted at cycle 40 of RUN) -> next cycle all outputs 0, state IDLE; a later start with win_len=5 runs normally.
- start, win_len=3, sig_in=32'hDEADBEEF at CAPTURE, golden=32'hDEADBEEF -> misr_clr high 1 cycle, misr_en high exactly 3 cycles, pass=1, ser_out sequence 1,1,1,1,0,1,1,1,... (LSB first) over 32 handshakes, done pulse once.
- golden=32'hDEADBEEE, same stimulus -> pass=0; unload still 32 bits.
- win_len=0 -> CLEAR then CAPTURE directly, misr_en never asserted, sig_in=0 captured, golden=0 -> pass=1.
- ser_ready toggled randomly, plus a 10-cycle stall on bit 7 -> ser_out/ser_valid stable during the stall, no bits lost or duplicated, start pulses during UNLOAD ignored.
- With MISR_SIG_PARITY_EN, sig_in=32'h00000007 -> 33rd bit=1, done after the 33rd handshake; without the macro, done after 32.
